// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM client arbiter.
// Arbiter states, mode encodings and client-index width helper.
package sram_arb_pkg;

    typedef enum logic {
        S_ARB_IDLE = 1'b0,
        S_ARB_OWN  = 1'b1
    } arb_state_type;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_client_arbiter_if.sv
// Client-side and SRAM-controller-side bundle of the arbiter.
// master = top FSM / clients / controller, slave = arbiter.
interface sram_client_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16
);
    logic                          Mode;
    logic [NUM_CLIENTS-1:0]        Req;
    logic [NUM_CLIENTS*ADDR_W-1:0] Client_address;
    logic [NUM_CLIENTS*DATA_W-1:0] Client_write_data;
    logic [NUM_CLIENTS-1:0]        Client_we_n;
    logic [NUM_CLIENTS-1:0]        Grant;
    logic [NUM_CLIENTS-1:0]        Read_valid;
    logic [DATA_W-1:0]             Read_data;
    logic [ADDR_W-1:0]             SRAM_address;
    logic [DATA_W-1:0]             SRAM_write_data;
    logic                          SRAM_we_n;
    logic [DATA_W-1:0]             SRAM_read_data;
    logic                          Busy;

    modport master (
        output Mode, Req, Client_address, Client_write_data,
        output Client_we_n, SRAM_read_data,
        input  Grant, Read_valid, Read_data, SRAM_address,
        input  SRAM_write_data, SRAM_we_n, Busy
    );

    modport slave (
        input  Mode, Req, Client_address, Client_write_data,
        input  Client_we_n, SRAM_read_data,
        output Grant, Read_valid, Read_data, SRAM_address,
        output SRAM_write_data, SRAM_we_n, Busy
    );
endinterface

// File: rtl/sram_client_arbiter_picker.sv
// Combinational winner picker for the SRAM client arbiter.
// Scans from a start index with wrap; start=0 gives fixed priority.
module arb_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     excl,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);
    int j;

    // First eligible requester at or after start wins
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!win_any && req[j] && !excl[j]) begin
                win_any   = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/sram_client_arbiter.sv
// N-client arbiter in front of the single SRAM controller port.
// Fixed/round-robin grant, bounded hold, tagged read return.
module sram_client_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int READ_LATENCY   = 2,
    parameter int MAX_HOLD       = 64,
    parameter int DEFAULT_CLIENT = 0
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    sram_client_arbiter_if.slave  bus
);
    localparam int N      = NUM_CLIENTS;
    localparam int L      = READ_LATENCY;
    localparam int IDX_W  = idx_width(NUM_CLIENTS);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_type         state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [N-1:0]          grant_q, grant_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [L-1:0]          pv_q, pv_d;
    logic [L-1:0][IDX_W-1:0] pi_q, pi_d;
    logic [N-1:0]          rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;

    logic                  owner_act;
    logic                  rd_push;
    logic                  at_limit;
    logic                  others;
    logic                  arb_go;
    logic [N-1:0]          excl;
    logic [IDX_W-1:0]      start;
    logic [N-1:0]          win_oh;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic                  sram_we_n;

    assign owner_act = |(grant_q & bus.Req);
    assign rd_push   = |(grant_q & bus.Req & bus.Client_we_n);
    assign at_limit  = (bus.Mode == ARB_RR) &&
                       (hold_q == HOLD_W'(MAX_HOLD));
    assign others    = |(bus.Req & ~grant_q);
    assign start     = (bus.Mode == ARB_RR) ? rr_ptr_q : '0;

    arb_rr_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (bus.Req),
        .excl    (excl),
        .start   (start),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    // Decide whether this edge re-arbitrates and whom to skip
    always_comb begin
        arb_go = 1'b0;
        excl   = '0;
        unique case (state_q)
            S_ARB_IDLE: arb_go = |bus.Req;
            S_ARB_OWN: begin
                if (!owner_act) begin
                    arb_go = 1'b1;
                end else if (at_limit && others) begin
                    arb_go = 1'b1;
                    excl   = grant_q;
                end
            end
            default: arb_go = 1'b0;
        endcase
    end

    // Next owner, grant, hold count and round-robin pointer
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        hold_d   = hold_q;
        rr_ptr_d = rr_ptr_q;
        if (arb_go) begin
            if (win_any) begin
                state_d = S_ARB_OWN;
                owner_d = win_idx;
                grant_d = win_oh;
                hold_d  = HOLD_W'(1);
                if (bus.Mode == ARB_RR) begin
                    rr_ptr_d = (int'(win_idx) == N - 1) ?
                               '0 : win_idx + 1'b1;
                end
            end else begin
                state_d = S_ARB_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        end else if (state_q == S_ARB_OWN) begin
            if (at_limit) begin
                hold_d = HOLD_W'(1);
            end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Route the owner's bus to SRAM; park on the default client otherwise
    always_comb begin
        sram_addr  = bus.Client_address[DEFAULT_CLIENT*ADDR_W +: ADDR_W];
        sram_wdata = bus.Client_write_data[DEFAULT_CLIENT*DATA_W +: DATA_W];
        sram_we_n  = 1'b1;
        if (owner_act) begin
            sram_addr  = bus.Client_address[int'(owner_q)*ADDR_W +: ADDR_W];
            sram_wdata = bus.Client_write_data[int'(owner_q)*DATA_W +: DATA_W];
            sram_we_n  = bus.Client_we_n[owner_q];
        end
    end

    // Tagged read pipeline matching the controller latency
    always_comb begin
        pv_d       = pv_q;
        pi_d       = pi_q;
        pv_d[0]    = rd_push;
        pi_d[0]    = owner_q;
        for (int i = 1; i < L; i++) begin
            pv_d[i] = pv_q[i-1];
            pi_d[i] = pi_q[i-1];
        end
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (pv_q[L-1]) begin
            rd_valid_d = {{(N-1){1'b0}}, 1'b1} << pi_q[L-1];
            rd_data_d  = bus.SRAM_read_data;
        end
    end

    // State and pipeline registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_ARB_IDLE;
            owner_q    <= '0;
            grant_q    <= '0;
            hold_q     <= '0;
            rr_ptr_q   <= '0;
            pv_q       <= '0;
            pi_q       <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            hold_q     <= hold_d;
            rr_ptr_q   <= rr_ptr_d;
            pv_q       <= pv_d;
            pi_q       <= pi_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.Grant           = grant_q;
    assign bus.Read_valid      = rd_valid_q;
    assign bus.Read_data       = rd_data_q;
    assign bus.SRAM_address    = sram_addr;
    assign bus.SRAM_write_data = sram_wdata;
    assign bus.SRAM_we_n       = sram_we_n;
    assign bus.Busy            = (|grant_q) | (|pv_q);
endmodule

// File: tb/tb_sram_client_arbiter.sv
// Self-checking bench for sram_client_arbiter.
// Vector table, directed corner sequences, random run vs reference model.
module tb_sram_client_arbiter;
    localparam int N   = 4;
    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int L   = 2;
    localparam int MH  = 4;
    localparam int DEF = 0;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    sram_client_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    sram_client_arbiter #(
        .NUM_CLIENTS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .READ_LATENCY   (L),
        .MAX_HOLD       (MH),
        .DEFAULT_CLIENT (DEF)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic          n_mode;
    logic [N-1:0]  n_req;
    logic [N-1:0]  n_wen;
    logic [AW-1:0] caddr [N];
    logic [DW-1:0] cwd   [N];
    logic [AW-1:0] hist  [64];

    logic [N-1:0]  obs_grant, obs_rv;
    logic [DW-1:0] obs_rd, obs_wd;
    logic [AW-1:0] obs_addr;
    logic          obs_we;

    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;

    typedef struct {
        int          due;
        int          cl;
        logic [DW-1:0] data;
    } rd_t;
    rd_t pend[$];

    typedef struct {
        logic         mode;
        logic [N-1:0] req;
        logic [N-1:0] wen;
        logic [N-1:0] exp_grant;
        logic         exp_we;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] sram_f(input logic [AW-1:0] a);
        if (a == 18'h00100) return 16'hA5A5;
        if (a == 18'h00200) return 16'h5A5A;
        return a[15:0] ^ {a[17:16], 14'h1A3C};
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int st,
                                input int ex);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (st + k) % N;
            if (r[j] && j != ex) return j;
        end
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0]  g_exp, rv_exp;
        logic [DW-1:0] rd_exp;
        logic [AW-1:0] a_exp;
        logic          act, we_exp, busy_exp;
        int            o, ex, w;
        bit            dec;
        @(posedge Clock);
        #1;
        cyc++;
        bus.Mode        = n_mode;
        bus.Req         = n_req;
        bus.Client_we_n = n_wen;
        for (int i = 0; i < N; i++) begin
            bus.Client_address[i*AW +: AW]    = caddr[i];
            bus.Client_write_data[i*DW +: DW] = cwd[i];
        end
        bus.SRAM_read_data = sram_f(hist[(cyc - L) & 63]);
        @(negedge Clock);
        o        = m_owner;
        act      = (o >= 0) && n_req[o];
        g_exp    = (o >= 0) ? (N'(1) << o) : '0;
        a_exp    = act ? caddr[o] : caddr[DEF];
        we_exp   = act ? n_wen[o] : 1'b1;
        rv_exp   = '0;
        rd_exp   = '0;
        busy_exp = (o >= 0);
        foreach (pend[k]) begin
            if (pend[k].due == cyc) begin
                rv_exp = N'(1) << pend[k].cl;
                rd_exp = pend[k].data;
            end
            if (pend[k].due > cyc) busy_exp = 1'b1;
        end
        obs_grant = bus.Grant;
        obs_rv    = bus.Read_valid;
        obs_rd    = bus.Read_data;
        obs_addr  = bus.SRAM_address;
        obs_we    = bus.SRAM_we_n;
        obs_wd    = bus.SRAM_write_data;
        hist[cyc & 63] = bus.SRAM_address;
        chk("grant", 32'(bus.Grant), 32'(g_exp));
        chk("sram_addr", 32'(bus.SRAM_address), 32'(a_exp));
        chk("sram_we_n", 32'(bus.SRAM_we_n), 32'(we_exp));
        if (act) chk("sram_wdata", 32'(bus.SRAM_write_data), 32'(cwd[o]));
        chk("read_valid", 32'(bus.Read_valid), 32'(rv_exp));
        if (rv_exp != '0) chk("read_data", 32'(bus.Read_data), 32'(rd_exp));
        chk("busy", 32'(bus.Busy), 32'(busy_exp));
        while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
        if (act && n_wen[o]) pend.push_back('{cyc + L + 1, o, sram_f(caddr[o])});
        dec = 0;
        ex  = -1;
        if (o < 0) begin
            dec = |n_req;
        end else if (!n_req[o]) begin
            dec = 1;
        end else if (n_mode && m_hold == MH) begin
            if ((n_req & ~(N'(1) << o)) != '0) begin
                dec = 1;
                ex  = o;
            end else begin
                m_hold = 1;
            end
        end else if (m_hold < MH) begin
            m_hold++;
        end
        if (dec) begin
            w = pick(n_req, n_mode ? m_ptr : 0, ex);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
                if (n_mode) m_ptr = (w + 1) % N;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end
    endtask

    task automatic reset_mid();
        @(posedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.Grant), 32'h0);
        chk("rst_we_n", 32'(bus.SRAM_we_n), 32'h1);
        chk("rst_rv", 32'(bus.Read_valid), 32'h0);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        n_req   = '0;
        bus.Req = '0;
        repeat (2) @(posedge Clock);
        #1;
        Resetn  = 1'b1;
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        pend.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e;
        tbl[0] = '{1'b0, 4'b1010, 4'hF,    4'b0000, 1'b1};
        tbl[1] = '{1'b0, 4'b1010, 4'hF,    4'b0010, 1'b1};
        tbl[2] = '{1'b0, 4'b1000, 4'hF,    4'b0010, 1'b1};
        tbl[3] = '{1'b0, 4'b1000, 4'hF,    4'b1000, 1'b1};
        tbl[4] = '{1'b0, 4'b1001, 4'hF,    4'b1000, 1'b1};
        tbl[5] = '{1'b0, 4'b0001, 4'hF,    4'b1000, 1'b1};
        tbl[6] = '{1'b0, 4'b0001, 4'b1110, 4'b0001, 1'b0};
        tbl[7] = '{1'b0, 4'b0000, 4'hF,    4'b0001, 1'b1};
        tbl[8] = '{1'b0, 4'b0000, 4'hF,    4'b0000, 1'b1};

        for (int i = 0; i < 64; i++) hist[i] = '0;
        n_mode = 1'b0;
        n_req  = '0;
        n_wen  = '1;
        for (int i = 0; i < N; i++) begin
            caddr[i] = AW'(i * 4096 + 12'hABC);
            cwd[i]   = DW'(16'h1111 * (i + 1));
        end
        bus.Mode           = 1'b0;
        bus.Req            = '0;
        bus.Client_we_n    = '1;
        bus.SRAM_read_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.Client_address[i*AW +: AW]    = caddr[i];
            bus.Client_write_data[i*DW +: DW] = cwd[i];
        end

        repeat (3) @(posedge Clock);
        #1;
        chk("reset_grant", 32'(bus.Grant), 32'h0);
        chk("reset_rv", 32'(bus.Read_valid), 32'h0);
        chk("reset_rdata", 32'(bus.Read_data), 32'h0);
        chk("reset_busy", 32'(bus.Busy), 32'h0);
        chk("reset_we_n", 32'(bus.SRAM_we_n), 32'h1);
        chk("reset_addr", 32'(bus.SRAM_address), 32'(caddr[DEF]));
        Resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            n_mode = tbl[i].mode;
            n_req  = tbl[i].req;
            n_wen  = tbl[i].wen;
            step();
            chk("tbl_grant", 32'(obs_grant), 32'(tbl[i].exp_grant));
            chk("tbl_we_n", 32'(obs_we), 32'(tbl[i].exp_we));
        end
        n_wen = '1;
        repeat (3) step();

        n_mode = 1'b1;
        n_req  = 4'hF;
        for (int k = 0; k < 20; k++) begin
            step();
            e = (k == 0) ? '0 : N'(1) << (((k - 1) / 4) % 4);
            chk("rr_grant", 32'(obs_grant), 32'(e));
        end
        n_req = '0;
        repeat (3) step();

        n_req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step();
            e = (k == 0) ? '0 : 4'b0001;
            chk("sole_grant", 32'(obs_grant), 32'(e));
        end
        n_req = '0;
        repeat (2) step();

        n_mode   = 1'b0;
        caddr[2] = 18'h00100;
        caddr[1] = 18'h00200;
        n_req = 4'b0100; step();
        n_req = 4'b0110; step();
        chk("tag_addr2", 32'(obs_addr), 32'h00100);
        n_req = 4'b0010; step();
        n_req = 4'b0010; step();
        chk("tag_addr1", 32'(obs_addr), 32'h00200);
        n_req = 4'b0000; step();
        chk("tag_rv2", 32'(obs_rv), 32'h4);
        chk("tag_rd2", 32'(obs_rd), 32'hA5A5);
        step();
        chk("tag_gap", 32'(obs_rv), 32'h0);
        step();
        chk("tag_rv1", 32'(obs_rv), 32'h2);
        chk("tag_rd1", 32'(obs_rd), 32'h5A5A);
        repeat (2) step();

        caddr[3] = 18'h3FFFF;
        cwd[3]   = 16'h1234;
        n_wen    = 4'b0111;
        n_req    = 4'b1000;
        step();
        step();
        chk("wr_we_n", 32'(obs_we), 32'h0);
        chk("wr_addr", 32'(obs_addr), 32'h3FFFF);
        chk("wr_data", 32'(obs_wd), 32'h1234);
        n_req = '0;
        repeat (3) step();
        chk("wr_no_rv", 32'(obs_rv), 32'h0);
        n_wen = '1;

        n_req = 4'b0010;
        repeat (3) step();
        chk("burst_busy", 32'(obs_grant), 32'h2);
        reset_mid();
        n_req = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst_rv", 32'(obs_rv), 32'h0);
        end

        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(15) == 0) n_mode = ~n_mode;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) n_req[i] = ~n_req[i];
                n_wen[i] = ($urandom_range(3) != 0);
                caddr[i] = AW'($urandom);
                cwd[i]   = DW'($urandom);
            end
            step();
        end
        n_req = '0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_client_arbiter.md
Name: sram_client_arbiter

Overview:
Parametrised N-client arbiter that generalises the fixed UART/M1/VGA SRAM multiplexing in the top level into a reusable block between any number of SRAM clients and the single SRAM_Controller port. Supports fixed-priority and round-robin arbitration, bounded grant hold, and returns tagged read data to the issuing client after the controller's read latency. Instantiated in the top level in place of the hand-written address/we_n mux; the top FSM drives Mode and the per-client requests.

Parameters:
NUM_CLIENTS, 4, number of clients (2..8); client 0 is highest fixed priority
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width
READ_LATENCY, 2, cycles from address on SRAM_address to valid SRAM_read_data (1..4)
MAX_HOLD, 64, max consecutive granted cycles before forced re-arbitration in round-robin mode (>=1)
DEFAULT_CLIENT, 0, client whose address is driven (with we_n=1) when no grant is held

Ports:
Clock  input  1  50 MHz system clock
Resetn  input  1  asynchronous active-low reset
Mode  input  1  0 = fixed priority, 1 = round-robin
Req  input  NUM_CLIENTS  per-client access request, level
Client_address  input  NUM_CLIENTS*ADDR_W  flattened, client i at [i*ADDR_W +: ADDR_W]
Client_write_data  input  NUM_CLIENTS*DATA_W  flattened, same packing
Client_we_n  input  NUM_CLIENTS  per-client active-low write enable
Grant  output  NUM_CLIENTS  one-hot, registered; at most one bit set
Read_valid  output  NUM_CLIENTS  one-hot pulse, read data for that client on Read_data
Read_data  output  DATA_W  registered copy of SRAM_read_data
SRAM_address  output  ADDR_W  to SRAM_Controller
SRAM_write_data  output  DATA_W  to SRAM_Controller
SRAM_we_n  output  1  to SRAM_Controller
SRAM_read_data  input  DATA_W  from SRAM_Controller
Busy  output  1  grant held or reads in flight

Behaviour:
- Clock/reset: single Clock; reset asynchronous, active-low on Resetn. Reset values: Grant=0, Read_valid=0, Read_data=0, Busy=0, hold counter=0, RR pointer=0, read pipeline flushed; SRAM_we_n=1, SRAM_address=DEFAULT_CLIENT address.
- States: S_ARB_IDLE (no owner), S_ARB_OWN (owner index registered).
- S_ARB_IDLE: if any Req, pick winner, set Grant next edge, go S_ARB_OWN, hold counter=1. Else stay.
- Winner, fixed: lowest index with Req set. Round-robin: first requester at or after (RR pointer), wrapping modulo NUM_CLIENTS; pointer then = winner+1 (wraps to 0).
- S_ARB_OWN: while owner's Req=1, keep Grant. Owner Req drops -> re-arbitrate same edge (another requester can be granted immediately, no idle bubble); none -> S_ARB_IDLE, Grant=0.
- Hold limit (Mode=1 only): when hold counter==MAX_HOLD and another client requests, re-arbitrate excluding current owner; if owner is sole requester, keep grant and restart counter at 1. Mode=0 ignores MAX_HOLD (counter saturates).
- Mode change takes effect only at next arbitration decision.
- SRAM outputs combinational from registered owner: SRAM_address/write_data/we_n = owner's inputs when Grant set and owner Req=1; else DEFAULT_CLIENT address, we_n=1. A grant-held cycle with owner Req=0 never writes.
- Read tracking: each cycle with Grant[i], Req[i]=1, Client_we_n[i]=1 pushes {valid,i} into a READ_LATENCY-deep shift register. At its output, Read_data registers SRAM_read_data and Read_valid[i] pulses one cycle (total READ_LATENCY+1 cycles after address cycle). Reads complete even if grant moves meanwhile; back-to-back reads give one Read_valid per cycle.
- Writes produce no Read_valid.
- Busy = |Grant or any valid in read pipeline.
- Reset mid-operation: in-flight reads discarded, no Read_valid after reset release until new reads issue.

Decomposition:
- Package sram_arb_pkg: arb_state_type enum {S_ARB_IDLE, S_ARB_OWN}; mode constants ARB_FIXED=1'b0, ARB_RR=1'b1; function for client-index width ($clog2 with minimum 1).
- One sub-module: arb_rr_picker (combinational: request vector, start pointer, exclude mask -> one-hot winner and index; start pointer=0 for fixed mode).

Test Plan:
- Fixed priority: Mode=0, Req=4'b1010 held -> Grant=4'b0010 next cycle; drop Req[1] -> Grant=4'b1000 same edge, no idle cycle.
- Round-robin fairness: Mode=1, MAX_HOLD=4, Req=4'b1111 held 20 cycles -> Grant rotates 0,1,2,3,0 in 4-cycle slots.
- Read tagging: client 2 reads addr 18'h00100 then client 1 reads 18'h00200 on consecutive grants; SRAM model returns 16'hA5A5/16'h5A5A -> Read_valid[2] with 16'hA5A5 then Read_valid[1] with 16'h5A5A, each READ_LATENCY+1 after its address cycle.
- Write passthrough: client 3 granted, we_n=0, address 18'h3FFFF, data 16'h1234 -> SRAM_we_n=0 with those values same cycle; no Read_valid.
- Sole requester over limit: Mode=1, only Req[0] for 10 cycles, MAX_HOLD=4 -> Grant stays 4'b0001 throughout.
- Reset mid-burst: assert Resetn=0 with 2 reads in flight -> Grant=0, SRAM_we_n=1 immediately; after release no Read_valid pulses.
